// File: rtl/snake_pkg.sv
// Shared snake-game types and default timing constants (scheduler and drawing engine).
// Pure declarations; no latency or backpressure of its own.
package snake_pkg;

  typedef enum logic [1:0] {
    STAGE_TITLE = 2'd0,
    STAGE_PLAY  = 2'd1,
    STAGE_OVER  = 2'd2
  } stage_t;

  typedef enum logic [1:0] {
    F_WAIT   = 2'd0,
    F_UPDATE = 2'd1,
    F_DRAW   = 2'd2
  } frame_state_t;

  localparam int unsigned DEF_DELAY_CYCLES = 1000000;
  localparam int unsigned DEF_MIN_DELAY    = 250000;
  localparam int unsigned DEF_SPEED_STEP   = 50000;
  localparam int unsigned DEF_DRAW_TIMEOUT = 65536;

  // Shorter delay after a speed-up, clamped at the floor; the 33rd bit catches underflow.
  function automatic logic [31:0] sped_up_delay(input logic [31:0] cur,
                                                input logic [31:0] step,
                                                input logic [31:0] floor_val);
    logic [32:0] diff;
    logic [31:0] result;
    diff   = {1'b0, cur} - {1'b0, step};
    result = diff[31:0];
    if (diff[32] || (diff[31:0] < floor_val)) result = floor_val;
    return result;
  endfunction

endpackage

// File: rtl/snake_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler (slave) and its surrounding game logic (master).
// Level signals only; update_req/update_ack and draw window form the flow control.
interface snake_frame_scheduler_if;

  logic        start;
  logic        update_ack;
  logic        collision;
  logic        ate_food;
  logic        draw_done;
  logic        update_req;
  logic        is_drawing;
  logic [31:0] stage;
  logic [31:0] cur_delay;
  logic [15:0] frame_count;
  logic        draw_timeout_err;

  modport master (
    output start, update_ack, collision, ate_food, draw_done,
    input  update_req, is_drawing, stage, cur_delay, frame_count, draw_timeout_err
  );

  modport slave (
    input  start, update_ack, collision, ate_food, draw_done,
    output update_req, is_drawing, stage, cur_delay, frame_count, draw_timeout_err
  );

endinterface

// File: rtl/snake_tick_counter.sv
// Loadable up/down cycle counter with a terminal-count compare; clear wins over load and count.
// Count updates one cycle after the enable; no backpressure.
module snake_tick_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_down,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_down ? (r_count - W'(1)) : (r_count + W'(1));
    end
  end

  assign o_tc = (r_count == i_term);

endmodule

// File: rtl/snake_frame_scheduler.sv
// Frame sequencer for the snake game: inter-frame delay, logic-update handshake, draw window.
// Owns the game stage and tick period; update phase waits indefinitely for update_ack.
module snake_frame_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int unsigned MIN_DELAY    = DEF_MIN_DELAY,
  parameter int unsigned SPEED_STEP   = DEF_SPEED_STEP,
  parameter int unsigned DRAW_TIMEOUT = DEF_DRAW_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     reset,
  snake_frame_scheduler_if.slave   sched
);

  localparam logic [31:0] LP_DELAY    = 32'(DELAY_CYCLES);
  localparam logic [31:0] LP_MIN      = 32'(MIN_DELAY);
  localparam logic [31:0] LP_STEP     = 32'(SPEED_STEP);
  localparam logic [31:0] LP_DRAW_END = 32'(DRAW_TIMEOUT - 1);

  frame_state_t r_state;
  stage_t       r_stage;
  logic         r_start_pending;
  logic         r_update_req;
  logic         r_is_drawing;
  logic         r_timeout_err;
  logic [31:0]  r_cur_delay;
  logic [15:0]  r_frame_count;

  logic         w_wait_tc;
  logic         w_draw_tc;
  logic         w_wait_exit;
  logic         w_draw_close;
  logic         w_ack;
  logic [31:0]  w_wait_term;

  assign w_wait_term  = r_cur_delay - 32'd1;
  assign w_wait_exit  = (r_state == F_WAIT) && w_wait_tc;
  // The timeout count only runs once the window is visibly open.
  assign w_draw_close = (r_state == F_DRAW) && (sched.draw_done || (r_is_drawing && w_draw_tc));
  assign w_ack        = (r_state == F_UPDATE) && r_update_req && sched.update_ack;

  snake_tick_counter #(.W(32)) u_delay_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_wait_exit),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .i_en       (r_state == F_WAIT),
    .i_down     (1'b0),
    .i_term     (w_wait_term),
    .o_tc       (w_wait_tc)
  );

  snake_tick_counter #(.W(32)) u_draw_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_draw_close),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .i_en       ((r_state == F_DRAW) && r_is_drawing),
    .i_down     (1'b0),
    .i_term     (LP_DRAW_END),
    .o_tc       (w_draw_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= F_WAIT;
      r_stage         <= STAGE_TITLE;
      r_start_pending <= 1'b0;
      r_update_req    <= 1'b0;
      r_is_drawing    <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_cur_delay     <= LP_DELAY;
      r_frame_count   <= 16'd0;
    end else begin
      // A start landing on the exit cycle itself survives into the next frame.
      r_start_pending <= (r_start_pending && !w_wait_exit) || sched.start;
      case (r_state)
        F_WAIT: begin
          if (w_wait_exit) begin
            if (r_start_pending) begin
              r_state <= F_DRAW;
              case (r_stage)
                STAGE_TITLE: begin
                  r_stage       <= STAGE_PLAY;
                  r_cur_delay   <= LP_DELAY;
                  r_frame_count <= 16'd0;
                end
                STAGE_OVER: r_stage <= STAGE_TITLE;
                default:    r_stage <= r_stage;
              endcase
            end else if (r_stage == STAGE_PLAY) begin
              r_state <= F_UPDATE;
            end else begin
              r_state <= F_DRAW;
            end
          end
        end
        F_UPDATE: begin
          if (w_ack) begin
            r_update_req <= 1'b0;
            r_state      <= F_DRAW;
            if (sched.collision) r_stage <= STAGE_OVER;
            if (sched.ate_food)  r_cur_delay <= sped_up_delay(r_cur_delay, LP_STEP, LP_MIN);
          end else begin
            r_update_req <= 1'b1;
          end
        end
        F_DRAW: begin
          if (w_draw_close) begin
            r_is_drawing  <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= F_WAIT;
            if (!sched.draw_done) r_timeout_err <= 1'b1;
          end else begin
            r_is_drawing <= 1'b1;
          end
        end
        default: r_state <= F_WAIT;
      endcase
    end
  end

  assign sched.update_req       = r_update_req;
  assign sched.is_drawing       = r_is_drawing;
  assign sched.stage            = {30'd0, r_stage};
  assign sched.cur_delay        = r_cur_delay;
  assign sched.frame_count      = r_frame_count;
  assign sched.draw_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_snake_frame_scheduler.sv
// Frame-level checks of snake_frame_scheduler against a per-frame reference model.
module tb_snake_frame_scheduler;

  localparam int DLY  = 10;
  localparam int MIN  = 4;
  localparam int STEP = 3;
  localparam int TMO  = 8;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  snake_frame_scheduler_if bus ();

  snake_frame_scheduler #(
    .DELAY_CYCLES (DLY),
    .MIN_DELAY    (MIN),
    .SPEED_STEP   (STEP),
    .DRAW_TIMEOUT (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sched (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model state: one update per frame, straight from the game rules.
  int m_stage, m_delay, m_fc;
  bit m_err;
  int exp_gap, exp_fcd, exp_win;
  bit exp_req;

  // Observations from one frame.
  int gap, req_len, draw_lat, fcd, win;
  bit saw_req, ok;

  task automatic model_reset();
    m_stage = 0; m_delay = DLY; m_fc = 0; m_err = 1'b0;
  endtask

  task automatic model_frame(input bit started, input bit coll, input bit food, input int done_at);
    exp_gap = m_delay + 1;
    exp_req = !started && (m_stage == 1);
    if (started) begin
      if (m_stage == 0) begin m_stage = 1; m_delay = DLY; m_fc = 0; end
      else if (m_stage == 2) m_stage = 0;
    end else if (exp_req) begin
      if (coll) m_stage = 2;
      if (food) m_delay = (m_delay - STEP < MIN) ? MIN : m_delay - STEP;
    end
    exp_fcd = m_fc;
    if (done_at < 1 || done_at > TMO) begin exp_win = TMO; m_err = 1'b1; end
    else exp_win = done_at;
    m_fc = (m_fc + 1) % 65536;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.update_ack = 1'b0; bus.collision = 1'b0;
    bus.ate_food = 1'b0; bus.draw_done = 1'b0;
  endtask

  // Runs one frame from the negedge after the previous window closed (or reset released).
  task automatic run_frame(input int start_at, input bit coll, input bit food, input int ack_wait,
                           input int done_at, input bit stray);
    int t0, t, k, n;
    ok = 1'b1; saw_req = 1'b0; req_len = 0; draw_lat = 0; win = 0; fcd = 0;
    t0 = cyc; k = 0;
    while (!(bus.update_req || bus.is_drawing) && k < 200) begin
      bus.start = (k == start_at);
      if (stray && k == 1) begin
        bus.update_ack = 1'b1; bus.collision = 1'b1; bus.ate_food = 1'b1; bus.draw_done = 1'b1;
      end else begin
        bus.update_ack = 1'b0; bus.collision = 1'b0; bus.ate_food = 1'b0; bus.draw_done = 1'b0;
      end
      @(negedge clock); k++;
    end
    clear_inputs();
    gap = cyc - t0;
    if (k >= 200) begin ok = 1'b0; return; end
    if (bus.update_req) begin
      saw_req = 1'b1; t = cyc;
      repeat (ack_wait) @(negedge clock);
      bus.update_ack = 1'b1; bus.collision = coll; bus.ate_food = food;
      @(negedge clock);
      clear_inputs();
      k = 0;
      while (bus.update_req && k < 20) begin @(negedge clock); k++; end
      req_len = cyc - t; t = cyc; k = 0;
      while (!bus.is_drawing && k < 20) begin @(negedge clock); k++; end
      draw_lat = cyc - t;
      if (k >= 20) begin ok = 1'b0; return; end
    end
    fcd = bus.frame_count;
    n = 0;
    while (bus.is_drawing && n < 50) begin
      n++;
      bus.draw_done = (n == done_at);
      @(negedge clock);
    end
    bus.draw_done = 1'b0;
    win = n;
    if (n >= 50) ok = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.stage !== 32'd0) begin errors++; $display("FAIL reset_stage got %0d want 0", bus.stage); end
    checks++; if (bus.update_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.update_req); end
    checks++; if (bus.is_drawing !== 1'b0) begin errors++; $display("FAIL reset_drawing got %b want 0", bus.is_drawing); end
    checks++; if (bus.cur_delay !== 32'(DLY)) begin errors++; $display("FAIL reset_delay got %0d want %0d", bus.cur_delay, DLY); end
    checks++; if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", bus.frame_count); end
    checks++; if (bus.draw_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.draw_timeout_err); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_title_frame();
    run_frame(-1, 1'b0, 1'b0, 0, 3, 1'b1);
    model_frame(1'b0, 1'b0, 1'b0, 3);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL title_timeout got %b want 1", ok); end
    checks++; if (gap !== exp_gap) begin errors++; $display("FAIL title_gap got %0d want %0d", gap, exp_gap); end
    checks++; if (saw_req !== exp_req) begin errors++; $display("FAIL title_req got %b want %b", saw_req, exp_req); end
    checks++; if (win !== exp_win) begin errors++; $display("FAIL title_window got %0d want %0d", win, exp_win); end
    checks++; if (bus.frame_count !== 16'(m_fc)) begin errors++; $display("FAIL title_fc got %0d want %0d", bus.frame_count, m_fc); end
    checks++; if (bus.stage !== 32'(m_stage)) begin errors++; $display("FAIL title_stage got %0d want %0d", bus.stage, m_stage); end
  endtask

  task automatic test_start_to_play();
    int s, aw, dn;
    for (int f = 0; f < 2; f++) begin
      s  = (f == 0) ? int'($urandom_range(0, m_delay - 2)) : -1;
      aw = $urandom_range(0, 4);
      dn = $urandom_range(1, TMO - 1);
      run_frame(s, 1'b0, 1'b0, aw, dn, 1'b0);
      model_frame(s >= 0, 1'b0, 1'b0, dn);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL start_timeout f%0d got %b want 1", f, ok); end
      checks++; if (gap !== exp_gap) begin errors++; $display("FAIL start_gap f%0d got %0d want %0d", f, gap, exp_gap); end
      checks++; if (saw_req !== exp_req) begin errors++; $display("FAIL start_req f%0d got %b want %b", f, saw_req, exp_req); end
      if (exp_req) begin
        checks++; if (req_len !== aw + 1) begin errors++; $display("FAIL start_reqlen got %0d want %0d", req_len, aw + 1); end
        checks++; if (draw_lat !== 1) begin errors++; $display("FAIL start_drawlat got %0d want 1", draw_lat); end
      end
      checks++; if (fcd !== exp_fcd) begin errors++; $display("FAIL start_fc_in_draw f%0d got %0d want %0d", f, fcd, exp_fcd); end
      checks++; if (bus.stage !== 32'(m_stage)) begin errors++; $display("FAIL start_stage f%0d got %0d want %0d", f, bus.stage, m_stage); end
      checks++; if (bus.frame_count !== 16'(m_fc)) begin errors++; $display("FAIL start_fc f%0d got %0d want %0d", f, bus.frame_count, m_fc); end
    end
  endtask

  task automatic test_speedup();
    int aw, dn;
    for (int f = 0; f < 5; f++) begin
      aw = $urandom_range(0, 3);
      dn = $urandom_range(1, TMO - 1);
      run_frame(-1, 1'b0, 1'b1, aw, dn, 1'b0);
      model_frame(1'b0, 1'b0, 1'b1, dn);
      checks++; if (gap !== exp_gap) begin errors++; $display("FAIL speed_gap f%0d got %0d want %0d", f, gap, exp_gap); end
      checks++; if (saw_req !== exp_req) begin errors++; $display("FAIL speed_req f%0d got %b want %b", f, saw_req, exp_req); end
      checks++; if (bus.cur_delay !== 32'(m_delay)) begin errors++; $display("FAIL speed_delay f%0d got %0d want %0d", f, bus.cur_delay, m_delay); end
      checks++; if (win !== exp_win) begin errors++; $display("FAIL speed_window f%0d got %0d want %0d", f, win, exp_win); end
    end
  endtask

  task automatic test_collision_restart();
    int st, dn;
    bit food;
    for (int f = 0; f < 4; f++) begin
      st   = (f >= 2) ? int'($urandom_range(0, m_delay - 2)) : -1;
      food = $urandom_range(0, 1);
      dn   = $urandom_range(1, TMO - 1);
      run_frame(st, (f == 0), food, $urandom_range(0, 2), dn, 1'b0);
      model_frame(st >= 0, (f == 0), food, dn);
      checks++; if (gap !== exp_gap) begin errors++; $display("FAIL coll_gap f%0d got %0d want %0d", f, gap, exp_gap); end
      checks++; if (saw_req !== exp_req) begin errors++; $display("FAIL coll_req f%0d got %b want %b", f, saw_req, exp_req); end
      checks++; if (bus.stage !== 32'(m_stage)) begin errors++; $display("FAIL coll_stage f%0d got %0d want %0d", f, bus.stage, m_stage); end
      checks++; if (bus.cur_delay !== 32'(m_delay)) begin errors++; $display("FAIL coll_delay f%0d got %0d want %0d", f, bus.cur_delay, m_delay); end
      checks++; if (fcd !== exp_fcd) begin errors++; $display("FAIL coll_fc_in_draw f%0d got %0d want %0d", f, fcd, exp_fcd); end
    end
  endtask

  task automatic test_draw_timeout();
    int dn_tab[4];
    dn_tab[0] = TMO;
    dn_tab[1] = -1;
    dn_tab[2] = $urandom_range(1, TMO - 1);
    dn_tab[3] = $urandom_range(1, TMO - 1);
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, 1'b0, 1'b0, $urandom_range(0, 2), dn_tab[f], 1'b0);
      model_frame(1'b0, 1'b0, 1'b0, dn_tab[f]);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_bound f%0d got %b want 1", f, ok); end
      checks++; if (win !== exp_win) begin errors++; $display("FAIL tmo_window f%0d got %0d want %0d", f, win, exp_win); end
      checks++; if (bus.draw_timeout_err !== m_err) begin errors++; $display("FAIL tmo_err f%0d got %b want %b", f, bus.draw_timeout_err, m_err); end
      checks++; if (bus.frame_count !== 16'(m_fc)) begin errors++; $display("FAIL tmo_fc f%0d got %0d want %0d", f, bus.frame_count, m_fc); end
    end
  endtask

  task automatic test_reset_mid_update();
    int k;
    k = 0;
    while (!bus.update_req && k < 100) begin @(negedge clock); k++; end
    checks++; if (bus.update_req !== 1'b1) begin errors++; $display("FAIL mid_req_seen got %b want 1", bus.update_req); end
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    checks++; if (bus.update_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", bus.update_req); end
    checks++; if (bus.stage !== 32'd0) begin errors++; $display("FAIL mid_stage got %0d want 0", bus.stage); end
    checks++; if (bus.cur_delay !== 32'(DLY)) begin errors++; $display("FAIL mid_delay got %0d want %0d", bus.cur_delay, DLY); end
    checks++; if (bus.draw_timeout_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", bus.draw_timeout_err); end
    reset = 1'b0;
    run_frame(-1, 1'b0, 1'b0, 0, 2, 1'b1);
    model_frame(1'b0, 1'b0, 1'b0, 2);
    checks++; if (gap !== exp_gap) begin errors++; $display("FAIL mid_gap got %0d want %0d", gap, exp_gap); end
    checks++; if (saw_req !== exp_req) begin errors++; $display("FAIL mid_stale_req got %b want %b", saw_req, exp_req); end
    checks++; if (bus.stage !== 32'(m_stage)) begin errors++; $display("FAIL mid_stale_stage got %0d want %0d", bus.stage, m_stage); end
    checks++; if (bus.frame_count !== 16'(m_fc)) begin errors++; $display("FAIL mid_fc got %0d want %0d", bus.frame_count, m_fc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    @(negedge clock);
    test_reset();
    test_title_frame();
    test_start_to_play();
    test_speedup();
    test_collision_restart();
    test_draw_timeout();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_frame_scheduler.md
Name: snake_frame_scheduler

Overview:
Frame-level controller for the snake game. It sequences each frame through three phases: an inter-frame delay, a game-logic update handshake, and a drawing window. It also owns the game stage register (TITLE / PLAY / OVER) and the tick period, which shortens as food is eaten. It sits between the input and button logic, the snake-logic datapath, and the VGA drawing engine.

Parameters:
DELAY_CYCLES, 1000000, initial inter-frame delay in clock cycles (>=2)
MIN_DELAY, 250000, floor for the delay after speed-ups (>=2, <=DELAY_CYCLES)
SPEED_STEP, 50000, delay reduction applied per food eaten
DRAW_TIMEOUT, 65536, maximum cycles the drawing window may stay open

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  button pulse; requests a stage change
update_ack  in  1  logic step finished; qualifies collision and ate_food
collision  in  1  snake hit wall or self; valid only with update_ack
ate_food  in  1  food eaten this step; valid only with update_ack
draw_done  in  1  drawing engine finished the frame
update_req  out  1  request one logic step
is_drawing  out  1  drawing window open
stage  out  32  0=TITLE, 1=PLAY, 2=OVER, zero-extended
cur_delay  out  32  current inter-frame delay
frame_count  out  16  frames completed since entering PLAY
draw_timeout_err  out  1  sticky; set when a draw window times out

Behaviour:
- All outputs are registered.
- Reset values: stage=0, update_req=0, is_drawing=0, cur_delay=DELAY_CYCLES, frame_count=0, draw_timeout_err=0. After reset the FSM is in F_WAIT with the delay counter at 0 and start_pending=0.
- Reset mid-operation: reset overrides everything. Any in-flight req or draw is abandoned; the values return to the reset values on the next edge.
- start handling: start sets sticky start_pending in any state. A start while already pending has no further effect. start_pending is consumed only when F_WAIT exits.
- F_WAIT: the counter increments each cycle. The exit decision is taken on the cycle where counter==cur_delay-1, and the counter is cleared.
  - If start_pending: apply the stage transition, clear pending, go to F_DRAW. This transition frame has no update step.
  - Else if stage==PLAY: go to F_UPDATE.
  - Else: go to F_DRAW.
- Stage transitions on start: TITLE->PLAY (also cur_delay<=DELAY_CYCLES, frame_count<=0); PLAY->PLAY (start ignored, pending cleared); OVER->TITLE.
- F_UPDATE:
  - update_req is 1 from the cycle after entry until the cycle after update_ack is seen with req=1. No timeout on this phase.
  - On ack: if collision, stage<=OVER. If ate_food, cur_delay<=max(cur_delay-SPEED_STEP, MIN_DELAY); compute in 33 bits, no underflow. Next state is F_DRAW.
  - If collision and ate_food arrive together, both apply.
  - update_ack while update_req=0 is ignored.
- F_DRAW:
  - is_drawing is 1 from the cycle after entry. A draw counter runs from 0.
  - draw_done, or draw counter reaching DRAW_TIMEOUT-1, closes the window: go to F_WAIT, is_drawing<=0, frame_count+1 (wraps at 16 bits).
  - If closed by timeout without draw_done, draw_timeout_err<=1. draw_done on the timeout cycle counts as done.
  - draw_done outside F_DRAW is ignored.
- Latency: first is_drawing rise occurs DELAY_CYCLES+1 cycles after reset deasserts.

Decomposition:
- Shared package snake_pkg holds:
  - stage encodings STAGE_TITLE/PLAY/OVER;
  - frame FSM state enum F_WAIT/F_UPDATE/F_DRAW;
  - default timing constants, also reused by the drawing engine.
- One natural sub-module: snake_tick_counter, a loadable down/up counter with terminal-count flag. It is instantiated twice, for the delay and the draw timeout.

Test Plan:
Parameters for all scenarios: DELAY_CYCLES=10, MIN_DELAY=4, SPEED_STEP=3, DRAW_TIMEOUT=8.
1. Release reset, then pulse draw_done 3 cycles into the window -> is_drawing rises 11 cycles after reset release and falls 1 cycle after draw_done; frame_count=1; stage=0; update_req never asserted.
2. Pulse start during F_WAIT -> stage=1 at the next boundary with no update_req that frame; the following frame update_req=1 until 1 cycle after update_ack.
3. In PLAY, ack with ate_food=1 on four consecutive frames -> cur_delay goes 10, 7, 4, 4, 4, and F_WAIT length tracks it.
4. Ack with collision=1 -> stage=2 and no further update_req. Then start -> stage=0. Then start -> stage=1, with cur_delay=10 and frame_count=0.
5. Withhold draw_done -> is_drawing high exactly 8 cycles, draw_timeout_err=1 and it stays 1 through later frames until reset.
6. Assert reset while update_req=1 -> next edge update_req=0, stage=0, cur_delay=10; a stale update_ack afterwards has no effect.
